// File: rtl/mem_fair_responder.sv
// mem_fair_responder
//   Multi-channel memory-bus responder for formal/simulation environments.
//   Each of NCH channels independently grants its request after a bounded,
//   nondeterministically chosen stall, checks that the request stays stable
//   while waiting, and counts completed transactions (saturating).
//
//   Optional feature macro: MEM_FAIR_RESP_ERR_EN
//     defined   : ch_err = ch_gnt & nd_err (error responses injected)
//     undefined : ch_err tied to 0, nd_err ignored
//
// Ports
//   f_clk, g_resetn           clock, asynchronous active-low reset
//   ch_req/addr/wen/strb/wdata request side, channel i at slice i
//   ch_gnt/err/rdata          response side
//   nd_stall/nd_err/nd_rdata  nondeterministic choices (stall, error, read data)
//   viol_stable, viol_drop    sticky protocol-violation flags
//   txn_count                 per-channel saturating completed-transaction count
module mem_fair_responder #(
  parameter int NCH        = 2,
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_DATA_W = 64,
  parameter int MEM_STRB_W = 8,
  parameter int MAX_STALL  = 7,
  parameter int SW         = 3,
  parameter int CNT_W      = 16
) (
  input  logic                      f_clk,
  input  logic                      g_resetn,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH*MEM_ADDR_W-1:0] ch_addr,
  input  logic [NCH-1:0]            ch_wen,
  input  logic [NCH*MEM_STRB_W-1:0] ch_strb,
  input  logic [NCH*MEM_DATA_W-1:0] ch_wdata,
  output logic [NCH-1:0]            ch_gnt,
  output logic [NCH-1:0]            ch_err,
  output logic [NCH*MEM_DATA_W-1:0] ch_rdata,
  input  logic [NCH*SW-1:0]         nd_stall,
  input  logic [NCH-1:0]            nd_err,
  input  logic [NCH*MEM_DATA_W-1:0] nd_rdata,
  output logic [NCH-1:0]            viol_stable,
  output logic [NCH-1:0]            viol_drop,
  output logic [NCH*CNT_W-1:0]      txn_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int            FLD_W     = MEM_ADDR_W + 1 + MEM_STRB_W + MEM_DATA_W;
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  function automatic logic [SW-1:0] clamp_stall(input logic [SW-1:0] s);
    return (s > STALL_MAX) ? STALL_MAX : s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifndef MEM_FAIR_RESP_ERR_EN
  logic unused_nd_err;
  assign unused_nd_err = ^nd_err;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]       state;
    logic [SW-1:0]    cnt;
    logic [SW-1:0]    stl;
    logic [FLD_W-1:0] fld;
    logic [FLD_W-1:0] snap;
    logic             req;
    logic             gnt;
    logic             vs_q;
    logic             vd_q;
    logic [CNT_W-1:0] txn_q;

    assign req = ch_req[i];
    assign stl = clamp_stall(nd_stall[i*SW +: SW]);
    assign fld = {ch_addr[i*MEM_ADDR_W +: MEM_ADDR_W], ch_wen[i],
                  ch_strb[i*MEM_STRB_W +: MEM_STRB_W],
                  ch_wdata[i*MEM_DATA_W +: MEM_DATA_W]};

    // Grant is combinational; gating with reset keeps every output at zero
    // while reset is held, even if a zero-stall request is present.
    always_comb begin
      gnt = 1'b0;
      if (g_resetn && req) begin
        if (state == ST_IDLE) gnt = (stl == '0);
        else                  gnt = (cnt == '0);
      end
    end

    always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        state <= ST_IDLE;
        cnt   <= '0;
        vs_q  <= 1'b0;
        vd_q  <= 1'b0;
        txn_q <= '0;
      end else begin
        if (state == ST_IDLE) begin
          // cnt counts the remaining WAIT cycles before the grant cycle,
          // so the grant lands exactly stl cycles after the first req cycle.
          if (req && (stl != '0)) begin
            state <= ST_WAIT;
            cnt   <= stl - 1'b1;
          end
        end else begin
          if (!req) begin
            state <= ST_IDLE;
            vd_q  <= 1'b1;
          end else begin
            if (fld != snap) vs_q <= 1'b1;
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        if (gnt) txn_q <= sat_inc(txn_q);
      end
    end

    // Request fields are captured on every idle request cycle; only the
    // capture taken when entering WAIT is ever compared against.
    always_ff @(posedge f_clk) begin
      if ((state == ST_IDLE) && req) snap <= fld;
    end

    assign ch_gnt[i]                          = gnt;
    assign ch_rdata[i*MEM_DATA_W +: MEM_DATA_W] =
      (gnt && !ch_wen[i]) ? nd_rdata[i*MEM_DATA_W +: MEM_DATA_W] : '0;
`ifdef MEM_FAIR_RESP_ERR_EN
    assign ch_err[i] = gnt & nd_err[i];
`else
    assign ch_err[i] = 1'b0;
`endif
    assign viol_stable[i]              = vs_q;
    assign viol_drop[i]                = vd_q;
    assign txn_count[i*CNT_W +: CNT_W] = txn_q;
  end

endmodule

// File: tb/tb_mem_fair_responder.sv
// Testbench for mem_fair_responder: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model
// (start cycle + stall gives the grant cycle; snapshot compare; saturating count).
module tb_mem_fair_responder;
  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int MS  = 5;
  localparam int SW  = 3;
  localparam int CW  = 2;
  localparam int FW  = AW + 1 + BW + DW;
  localparam int CMAX = (1 << CW) - 1;

  logic                f_clk = 1'b0;
  logic                g_resetn;
  logic [NCH-1:0]      ch_req, ch_wen, nd_err;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*BW-1:0]   ch_strb;
  logic [NCH*DW-1:0]   ch_wdata, nd_rdata, ch_rdata;
  logic [NCH*SW-1:0]   nd_stall;
  logic [NCH-1:0]      ch_gnt, ch_err, viol_stable, viol_drop;
  logic [NCH*CW-1:0]   txn_count;

  mem_fair_responder #(
    .NCH(NCH), .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(BW),
    .MAX_STALL(MS), .SW(SW), .CNT_W(CW)
  ) dut (
    .f_clk(f_clk), .g_resetn(g_resetn),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_wen(ch_wen), .ch_strb(ch_strb),
    .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .nd_stall(nd_stall), .nd_err(nd_err), .nd_rdata(nd_rdata),
    .viol_stable(viol_stable), .viol_drop(viol_drop), .txn_count(txn_count)
  );

  always #5 f_clk = ~f_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  bit            m_busy [NCH];
  int            m_due  [NCH];
  logic [FW-1:0] m_snap [NCH];
  bit            m_vs   [NCH];
  bit            m_vd   [NCH];
  int            m_cnt  [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fields(input int i);
    return {ch_addr[i*AW +: AW], ch_wen[i], ch_strb[i*BW +: BW], ch_wdata[i*DW +: DW]};
  endfunction

  function automatic int eff_stall(input int i);
    int s;
    s = int'(nd_stall[i*SW +: SW]);
    return (s > MS) ? MS : s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_busy[i] = 0; m_due[i] = 0; m_vs[i] = 0; m_vd[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic set_ch(input int i, input bit req, input logic [AW-1:0] addr,
                        input bit wen, input logic [DW-1:0] wdata, input int stall);
    ch_req[i]             = req;
    ch_addr[i*AW +: AW]   = addr;
    ch_wen[i]             = wen;
    ch_strb[i*BW +: BW]   = wen ? {BW{1'b1}} : '0;
    ch_wdata[i*DW +: DW]  = wdata;
    nd_stall[i*SW +: SW]  = SW'(stall);
  endtask

  // One clock cycle: called at a negedge with request inputs already set.
  task automatic cycle();
    logic [NCH-1:0]    eg, ee, evs, evd;
    logic [NCH*DW-1:0] er;
    logic [NCH*CW-1:0] ec;
    nd_rdata = {$urandom, $urandom};
    nd_err   = NCH'($urandom);
    #1;
    if (!g_resetn) model_clear();
    for (int i = 0; i < NCH; i++) begin
      eg[i] = 1'b0;
      if (g_resetn && ch_req[i]) begin
        if (!m_busy[i]) eg[i] = (eff_stall(i) == 0);
        else            eg[i] = (cyc == m_due[i]);
      end
      er[i*DW +: DW] = (eg[i] && !ch_wen[i]) ? nd_rdata[i*DW +: DW] : '0;
`ifdef MEM_FAIR_RESP_ERR_EN
      ee[i] = eg[i] & nd_err[i];
`else
      ee[i] = 1'b0;
`endif
      evs[i] = m_vs[i];
      evd[i] = m_vd[i];
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    chk("gnt", 64'(ch_gnt), 64'(eg));
    chk("err", 64'(ch_err), 64'(ee));
    chk("rdata", 64'(ch_rdata), 64'(er));
    chk("viol_stable", 64'(viol_stable), 64'(evs));
    chk("viol_drop", 64'(viol_drop), 64'(evd));
    chk("txn_count", 64'(txn_count), 64'(ec));
    if (g_resetn) begin
      for (int i = 0; i < NCH; i++) begin
        if (!m_busy[i]) begin
          if (ch_req[i] && eff_stall(i) > 0) begin
            m_busy[i] = 1;
            m_due[i]  = cyc + eff_stall(i);
            m_snap[i] = fields(i);
          end
        end else if (!ch_req[i]) begin
          m_busy[i] = 0;
          m_vd[i]   = 1;
        end else begin
          if (fields(i) != m_snap[i]) m_vs[i] = 1;
          if (cyc == m_due[i]) m_busy[i] = 0;
        end
        if (eg[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      end
    end
    cyc++;
    @(negedge f_clk);
  endtask

  initial begin
    model_clear();
    g_resetn = 1'b0;
    ch_req = '0; ch_addr = '0; ch_wen = '0; ch_strb = '0; ch_wdata = '0;
    nd_stall = '0; nd_err = '0; nd_rdata = '0;
    @(negedge f_clk);

    // Reset held with a zero-stall request present: nothing may respond.
    set_ch(0, 1, 16'h0100, 0, 0, 0);
    cycle(); cycle();
    set_ch(0, 0, 16'h0100, 0, 0, 0);
    g_resetn = 1'b1;
    cycle();

    // ch0 zero-stall read: same-cycle grant.
    set_ch(0, 1, 16'h1000, 0, 0, 0);
    cycle();
    set_ch(0, 0, 16'h1000, 0, 0, 0);
    #1 chk("rd0_count", 64'(txn_count[CW-1:0]), 64'd1);

    // ch1 write, stall 3: grant exactly 3 cycles after req rises.
    set_ch(1, 1, 16'h2000, 1, 32'hCAFEF00D, 3);
    cycle();
    nd_stall[SW +: SW] = 3'd0;
    cycle(); cycle();
    #1 chk("wr1_lat3", 64'(ch_gnt[1]), 64'd1);
    cycle();
    set_ch(1, 0, 16'h2000, 1, 32'hCAFEF00D, 3);
    cycle();

    // ch0 stall 7 clamps to 5.
    set_ch(0, 1, 16'h3000, 0, 0, 7);
    cycle();
    repeat (4) cycle();
    #1 chk("clamp5", 64'(ch_gnt[0]), 64'd1);
    cycle();
    set_ch(0, 0, 16'h3000, 0, 0, 0);
    cycle();

    // Address changes while waiting -> sticky viol_stable.
    set_ch(0, 1, 16'h1000, 0, 0, 4);
    cycle();
    ch_addr[AW-1:0] = 16'h1008;
    cycle();
    #1 chk("vs_set", 64'(viol_stable[0]), 64'd1);
    repeat (3) cycle();
    set_ch(0, 0, 16'h1008, 0, 0, 0);
    repeat (3) cycle();
    #1 chk("vs_sticky", 64'(viol_stable[0]), 64'd1);

    // Reset asserted mid-WAIT with cnt=2 clears everything at once.
    set_ch(1, 1, 16'h4000, 0, 0, 5);
    repeat (3) cycle();
    g_resetn = 1'b0;
    #1;
    chk("rst_gnt", 64'(ch_gnt), 64'd0);
    chk("rst_vs", 64'(viol_stable), 64'd0);
    chk("rst_cnt", 64'(txn_count), 64'd0);
    cycle(); cycle();
    g_resetn = 1'b1;
    set_ch(1, 1, 16'h4000, 0, 0, 0);
    cycle();
    set_ch(1, 0, 16'h4000, 0, 0, 0);
    cycle();

    // req dropped during WAIT -> viol_drop, no grant.
    set_ch(0, 1, 16'h5000, 0, 0, 3);
    cycle(); cycle();
    set_ch(0, 0, 16'h5000, 0, 0, 0);
    cycle();
    #1 chk("vd_set", 64'(viol_drop[0]), 64'd1);
    cycle();

    // Five back-to-back zero-stall reads saturate the 2-bit counter.
    set_ch(0, 1, 16'h6000, 0, 0, 0);
    repeat (5) cycle();
    set_ch(0, 0, 16'h6000, 0, 0, 0);
    #1 chk("sat3", 64'(txn_count[CW-1:0]), 64'd3);
    cycle();

    // Random traffic in two phases separated by a reset.
    for (int ph = 0; ph < 2; ph++) begin
      g_resetn = 1'b0;
      cycle();
      g_resetn = 1'b1;
      for (int n = 0; n < 200; n++) begin
        for (int i = 0; i < NCH; i++) begin
          if (m_busy[i]) begin
            ch_req[i] = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 19) == 0) ch_addr[i*AW +: AW] = AW'($urandom);
            nd_stall[i*SW +: SW] = SW'($urandom);
          end else begin
            set_ch(i, 1'($urandom), AW'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 7)));
          end
        end
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_fair_responder.md
Name: mem_fair_responder

Overview:
- Parametrised, multi-channel memory-bus responder for formal and simulation environments around core_top.
- Generalises the single-imem/dmem random-grant scheme used so far to NCH independent req/gnt channels.
- Grant latency per transaction is bounded and chosen nondeterministically; error injection is optional.
- Checks request-stability protocol rules, flags violations, and counts completed transactions per channel.

Parameters:
- NCH, 2, number of independent memory channels (>=1).
- MEM_ADDR_W, 64, address width per channel.
- MEM_DATA_W, 64, data width per channel.
- MEM_STRB_W, 8, write strobe width per channel (MEM_DATA_W/8).
- MAX_STALL, 7, maximum stall cycles before grant (fairness bound, >=0).
- SW, 3, width of each stall-select input; must satisfy 2**SW > MAX_STALL.
- CNT_W, 16, width of each per-channel transaction counter.

Ports:
- f_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- ch_req  in  NCH  per-channel request
- ch_addr  in  NCH*MEM_ADDR_W  request address, channel i at slice i
- ch_wen  in  NCH  write enable
- ch_strb  in  NCH*MEM_STRB_W  write strobes
- ch_wdata  in  NCH*MEM_DATA_W  write data
- ch_gnt  out  NCH  response valid / transaction complete
- ch_err  out  NCH  response error
- ch_rdata  out  NCH*MEM_DATA_W  read response data
- nd_stall  in  NCH*SW  nondeterministic stall select, sampled at request start
- nd_err  in  NCH  nondeterministic error select
- nd_rdata  in  NCH*MEM_DATA_W  nondeterministic read data
- viol_stable  out  NCH  sticky: request fields changed while waiting
- viol_drop  out  NCH  sticky: req deasserted before gnt
- txn_count  out  NCH*CNT_W  saturating completed-transaction count

Behaviour:
- Channels are fully independent; no shared state or arbitration.
- Per-channel FSM with states IDLE and WAIT. Reset state is IDLE.
- Reset values: all ch_gnt, ch_err, ch_rdata, viol_* and txn_count = 0.
- Effective stall: stl = min(nd_stall[i], MAX_STALL).
- IDLE, req=1, stl=0: ch_gnt=1 combinationally in the same cycle; stay in IDLE.
- IDLE, req=1, stl>0:
  - ch_gnt=0; load cnt=stl-1; go to WAIT.
  - Snapshot addr, wen, strb and wdata.
- WAIT, req=1:
  - If cnt=0: ch_gnt=1 and go to IDLE next cycle.
  - Otherwise decrement cnt.
- WAIT, req=0: set viol_drop; go to IDLE; no grant.
- WAIT, req=1, any of addr/wen/strb/wdata differs from the snapshot: set viol_stable in the next cycle. Grant timing is unaffected.
- Latency: grant arrives exactly stl cycles after the first req cycle, so at most MAX_STALL cycles.
- Back-to-back: req held high after a gnt cycle starts a new transaction next cycle, sampling a fresh nd_stall.
- ch_rdata = nd_rdata slice when ch_gnt && !ch_wen, else 0.
- txn_count increments on every cycle with ch_gnt=1 and saturates at 2**CNT_W-1 (no wrap).
- viol_* stay high until reset.
- Reset asserted mid-WAIT: FSM returns to IDLE immediately and all outputs clear asynchronously.

Optional Feature:
- Macro: MEM_FAIR_RESP_ERR_EN.
- Defined: ch_err = ch_gnt && nd_err[i]. On an errored read, ch_rdata is still driven from nd_rdata. An errored transaction still increments txn_count.
- Undefined: ch_err is tied to 0 and nd_err is ignored.

Test Plan:
- NCH=2, ch0 read, nd_stall=0 -> ch_gnt[0]=1 in the same cycle as req, ch_rdata = nd_rdata, txn_count[0]=1.
- ch1 write, nd_stall=3 -> ch_gnt[1] exactly 3 cycles after req rises, ch_rdata[1]=0, ch0 unaffected.
- nd_stall=7, MAX_STALL=5 -> grant after 5 cycles.
- ch0 addr changes 0x1000->0x1008 during WAIT -> viol_stable[0]=1 the next cycle and stays high until reset. Separately, req dropped during WAIT -> viol_drop=1 and no gnt.
- CNT_W=2, 5 back-to-back zero-stall reads -> txn_count saturates at 3.
- g_resetn=0 mid-WAIT with cnt=2 -> ch_gnt, viol_* and txn_count all 0 immediately; first req after release follows IDLE rules. With MEM_FAIR_RESP_ERR_EN and nd_err=1 -> ch_err=1 only in the grant cycle.
